// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the host-side UART command source: command encodings,
// protocol opcodes and per-command byte counts.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_REG_WR  = 2'd0,
    CMD_REG_RD  = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  localparam logic [7:0] OPC_REG_WR  = 8'hAA;
  localparam logic [7:0] OPC_REG_RD  = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  localparam int NBYTES_REG_WR  = 3;
  localparam int NBYTES_REG_RD  = 2;
  localparam int NBYTES_ALU_OP  = 4;
  localparam int NBYTES_ALU_NOP = 2;

  // Substituted whenever the requested prescale is too small to frame a bit.
  localparam int DEFAULT_PRESCALE = 8;

  function automatic logic [1:0] last_byte_idx(input cmd_type_e t);
    logic [1:0] idx;
    case (t)
      CMD_REG_WR: idx = 2'(NBYTES_REG_WR - 1);
      CMD_REG_RD: idx = 2'(NBYTES_REG_RD - 1);
      CMD_ALU_OP: idx = 2'(NBYTES_ALU_OP - 1);
      default:    idx = 2'(NBYTES_ALU_NOP - 1);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_byte_ser.sv
// Single-byte UART serializer: start, LSB-first data, optional parity, stop.
// A new byte may be launched from idle or in the last cycle of the stop bit.
module uart_byte_ser #(
  parameter int DATA_WIDTH      = 8,
  parameter int PRESCALER_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       byte_vld,
  input  logic [DATA_WIDTH-1:0]      byte_data,
  input  logic                       par_en,
  input  logic                       par_typ,
  input  logic [PRESCALER_WIDTH-1:0] prescale,
  output logic                       tx_out,
  output logic                       byte_done
);

  localparam int BCW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    BS_IDLE,
    BS_START,
    BS_DATA,
    BS_PARITY,
    BS_STOP
  } bit_state_e;

  bit_state_e                 state_q, state_d;
  logic [PRESCALER_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [BCW-1:0]             bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0]      shift_q, shift_d;
  logic                       par_q, par_d;
  logic                       tx_q, tx_d;
  logic                       bit_end;

  assign bit_end   = (pcnt_q == prescale - 1'b1);
  assign byte_done = (state_q == BS_STOP) && bit_end;
  assign tx_out    = tx_q;

  always_comb begin
    state_d = state_q;
    pcnt_d  = '0;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    if (state_q != BS_IDLE) begin
      pcnt_d = bit_end ? '0 : pcnt_q + 1'b1;
    end
    case (state_q)
      BS_IDLE: tx_d = 1'b1;
      BS_START: begin
        if (bit_end) begin
          state_d = BS_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bcnt_d  = '0;
        end
      end
      BS_DATA: begin
        if (bit_end) begin
          if (bcnt_q == BCW'(DATA_WIDTH - 1)) begin
            state_d = par_en ? BS_PARITY : BS_STOP;
            tx_d    = par_en ? par_q : 1'b1;
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      BS_PARITY: begin
        if (bit_end) begin
          state_d = BS_STOP;
          tx_d    = 1'b1;
        end
      end
      BS_STOP: begin
        if (bit_end) begin
          state_d = BS_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = BS_IDLE;
    endcase
    // Launch overrides the stop->idle exit so consecutive bytes abut.
    if (byte_vld && ((state_q == BS_IDLE) || byte_done)) begin
      state_d = BS_START;
      tx_d    = 1'b0;
      pcnt_d  = '0;
      shift_d = byte_data;
      par_d   = (^byte_data) ^ par_typ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BS_IDLE;
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_cmd_frame_tx.sv
// Host-side command source: registers one command, sequences its protocol bytes
// through the byte serializer, and reports ready/busy/done around the transfer.
module uart_cmd_frame_tx
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 4,
  parameter int PRESCALER_WIDTH = 6,
  parameter int GAP_BITS        = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CMD_VLD,
  output logic                       CMD_RDY,
  input  logic [1:0]                 CMD_TYPE,
  input  logic [ADDR_WIDTH-1:0]      CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]      CMD_WDATA,
  input  logic [DATA_WIDTH-1:0]      CMD_OP_A,
  input  logic [DATA_WIDTH-1:0]      CMD_OP_B,
  input  logic [3:0]                 CMD_FUN,
  input  logic                       PAR_EN,
  input  logic                       PAR_TYP,
  input  logic [PRESCALER_WIDTH-1:0] Prescale,
  output logic                       TX_OUT,
  output logic                       BUSY,
  output logic                       FRAME_DONE
);

  localparam int GAP_CW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_GAP
  } seq_state_e;

  seq_state_e                 state_q, state_d;
  cmd_type_e                  cmd_type_q, cmd_type_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]      op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]      op_b_q, op_b_d;
  logic [3:0]                 fun_q, fun_d;
  logic                       par_en_q, par_en_d;
  logic                       par_typ_q, par_typ_d;
  logic [PRESCALER_WIDTH-1:0] prescale_q, prescale_d;
  logic [1:0]                 byte_idx_q, byte_idx_d;
  logic [PRESCALER_WIDTH-1:0] gap_pcnt_q, gap_pcnt_d;
  logic [GAP_CW-1:0]          gap_bcnt_q, gap_bcnt_d;
  logic                       busy_q, busy_d;
  logic                       rdy_q, rdy_d;
  logic                       done_q, done_d;

  logic                       byte_vld;
  logic                       byte_done;
  logic [DATA_WIDTH-1:0]      byte_data;
  logic [1:0]                 launch_idx;
  logic                       more_bytes;
  logic                       gap_bit_end;
  logic                       gap_end;

  assign launch_idx  = (state_q == S_LOAD) ? 2'd0 : byte_idx_q + 2'd1;
  assign more_bytes  = (byte_idx_q != last_byte_idx(cmd_type_q));
  assign gap_bit_end = (gap_pcnt_q == prescale_q - 1'b1);
  assign gap_end     = (state_q == S_GAP) && gap_bit_end &&
                       (gap_bcnt_q == GAP_CW'(GAP_BITS - 1));
  assign byte_vld    = (state_q == S_LOAD) || gap_end ||
                       ((state_q == S_SEND) && byte_done && more_bytes && (GAP_BITS == 0));

  always_comb begin
    byte_data = '0;
    case (cmd_type_q)
      CMD_REG_WR: begin
        case (launch_idx)
          2'd0:    byte_data = DATA_WIDTH'(OPC_REG_WR);
          2'd1:    byte_data = DATA_WIDTH'(addr_q);
          default: byte_data = wdata_q;
        endcase
      end
      CMD_REG_RD: byte_data = (launch_idx == 2'd0) ? DATA_WIDTH'(OPC_REG_RD) : DATA_WIDTH'(addr_q);
      CMD_ALU_OP: begin
        case (launch_idx)
          2'd0:    byte_data = DATA_WIDTH'(OPC_ALU_OP);
          2'd1:    byte_data = op_a_q;
          2'd2:    byte_data = op_b_q;
          default: byte_data = DATA_WIDTH'(fun_q);
        endcase
      end
      default: byte_data = (launch_idx == 2'd0) ? DATA_WIDTH'(OPC_ALU_NOP) : DATA_WIDTH'(fun_q);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_type_d = cmd_type_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    fun_d      = fun_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    prescale_d = prescale_q;
    byte_idx_d = byte_idx_q;
    gap_pcnt_d = gap_pcnt_q;
    gap_bcnt_d = gap_bcnt_q;
    busy_d     = busy_q;
    rdy_d      = rdy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CMD_VLD && rdy_q) begin
          state_d    = S_LOAD;
          cmd_type_d = cmd_type_e'(CMD_TYPE);
          addr_d     = CMD_ADDR;
          wdata_d    = CMD_WDATA;
          op_a_d     = CMD_OP_A;
          op_b_d     = CMD_OP_B;
          fun_d      = CMD_FUN;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          prescale_d = (Prescale < PRESCALER_WIDTH'(2)) ? PRESCALER_WIDTH'(DEFAULT_PRESCALE) : Prescale;
          byte_idx_d = 2'd0;
          busy_d     = 1'b1;
          rdy_d      = 1'b0;
        end
      end
      S_LOAD: state_d = S_SEND;
      S_SEND: begin
        if (byte_done) begin
          if (!more_bytes) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
            done_d  = 1'b1;
          end else if (GAP_BITS == 0) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            state_d    = S_GAP;
            gap_pcnt_d = '0;
            gap_bcnt_d = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_end) begin
          state_d    = S_SEND;
          byte_idx_d = byte_idx_q + 2'd1;
        end else if (gap_bit_end) begin
          gap_pcnt_d = '0;
          gap_bcnt_d = gap_bcnt_q + 1'b1;
        end else begin
          gap_pcnt_d = gap_pcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cmd_type_q <= CMD_REG_WR;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      fun_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
      byte_idx_q <= '0;
      gap_pcnt_q <= '0;
      gap_bcnt_q <= '0;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_type_q <= cmd_type_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      fun_q      <= fun_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      prescale_q <= prescale_d;
      byte_idx_q <= byte_idx_d;
      gap_pcnt_q <= gap_pcnt_d;
      gap_bcnt_q <= gap_bcnt_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
    end
  end

  uart_byte_ser #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PRESCALER_WIDTH(PRESCALER_WIDTH)
  ) u_byte_ser (
    .clk      (CLK),
    .rst_n    (RST),
    .byte_vld (byte_vld),
    .byte_data(byte_data),
    .par_en   (par_en_q),
    .par_typ  (par_typ_q),
    .prescale (prescale_q),
    .tx_out   (TX_OUT),
    .byte_done(byte_done)
  );

  assign CMD_RDY    = rdy_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Bench for uart_cmd_frame_tx: a mid-bit sampling UART receiver pops expected
// bytes pushed at command time; scenario tasks check timing and handshakes.
module tb_uart_cmd_frame_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CMD_VLD = 1'b0;
  logic       CMD_RDY;
  logic [1:0] CMD_TYPE = 2'd0;
  logic [3:0] CMD_ADDR = 4'd0;
  logic [7:0] CMD_WDATA = 8'd0;
  logic [7:0] CMD_OP_A = 8'd0;
  logic [7:0] CMD_OP_B = 8'd0;
  logic [3:0] CMD_FUN = 4'd0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       TX_OUT;
  logic       BUSY;
  logic       FRAME_DONE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         p;
    bit         pe;
  } exp_t;

  exp_t exp_q[$];

  uart_cmd_frame_tx dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VLD   (CMD_VLD),
    .CMD_RDY   (CMD_RDY),
    .CMD_TYPE  (CMD_TYPE),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_WDATA (CMD_WDATA),
    .CMD_OP_A  (CMD_OP_A),
    .CMD_OP_B  (CMD_OP_B),
    .CMD_FUN   (CMD_FUN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Receiver: detects the start bit on a falling-edge sample, then samples each
  // bit near its middle using the prescale/parity of the expected frame.
  bit         rx_busy = 1'b0;
  bit         rx_unexp = 1'b0;
  int         rx_cnt = 0;
  int         rx_nb = 10;
  logic [10:0] rx_bits = '1;
  exp_t       rx_e;

  always @(negedge CLK) begin
    if (RST !== 1'b1) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (TX_OUT === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rx_unexpected_frame: start bit at cycle %0d, expected none", cyc);
          rx_unexp = 1'b1;
          rx_e = '{data: 8'h00, par: 1'b0, p: 8, pe: 1'b0};
        end else begin
          rx_unexp = 1'b0;
          rx_e = exp_q[0];
        end
        rx_busy = 1'b1;
        rx_cnt  = 0;
        rx_nb   = rx_e.pe ? 11 : 10;
        rx_bits = '1;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= rx_e.p / 2 && ((rx_cnt - rx_e.p / 2) % rx_e.p) == 0) begin
        int k;
        k = (rx_cnt - rx_e.p / 2) / rx_e.p;
        rx_bits[k] = TX_OUT;
        if (k == rx_nb - 1) begin
          rx_busy = 1'b0;
          if (!rx_unexp) begin
            void'(exp_q.pop_front());
            checks++;
            if (rx_bits[0] !== 1'b0) begin
              errors++;
              $display("[TB] FAIL rx_start_bit: got %b expected 0", rx_bits[0]);
            end
            checks++;
            if (rx_bits[8:1] !== rx_e.data) begin
              errors++;
              $display("[TB] FAIL rx_data: got %h expected %h", rx_bits[8:1], rx_e.data);
            end
            if (rx_e.pe) begin
              checks++;
              if (rx_bits[9] !== rx_e.par) begin
                errors++;
                $display("[TB] FAIL rx_parity: byte %h got %b expected %b", rx_e.data, rx_bits[9], rx_e.par);
              end
            end
            checks++;
            if (rx_bits[rx_nb-1] !== 1'b1) begin
              errors++;
              $display("[TB] FAIL rx_stop_bit: byte %h got %b expected 1", rx_e.data, rx_bits[rx_nb-1]);
            end
          end
        end
      end
    end
  end

  function automatic int calc_latency(input int n, input bit pe, input int p);
    return n * (10 + (pe ? 1 : 0)) * p + 1;
  endfunction

  // Must be called at a falling edge; returns the cycle index of the accept edge.
  task automatic drive_cmd(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] wd,
                           input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                           input bit pe, input bit pt, input logic [5:0] p,
                           output int acc_cyc, output int n);
    logic [7:0] bytes [4];
    int peff;
    int w;
    exp_t e;
    peff = (p < 6'd2) ? 8 : int'(p);
    bytes = '{default: 8'h00};
    case (t)
      2'd0: begin bytes[0] = 8'hAA; bytes[1] = {4'h0, addr}; bytes[2] = wd; n = 3; end
      2'd1: begin bytes[0] = 8'hBB; bytes[1] = {4'h0, addr}; n = 2; end
      2'd2: begin bytes[0] = 8'hCC; bytes[1] = a; bytes[2] = b; bytes[3] = {4'h0, fun}; n = 4; end
      default: begin bytes[0] = 8'hDD; bytes[1] = {4'h0, fun}; n = 2; end
    endcase
    CMD_TYPE  = t;
    CMD_ADDR  = addr;
    CMD_WDATA = wd;
    CMD_OP_A  = a;
    CMD_OP_B  = b;
    CMD_FUN   = fun;
    PAR_EN    = pe;
    PAR_TYP   = pt;
    Prescale  = p;
    CMD_VLD   = 1'b1;
    w = 0;
    while (CMD_RDY !== 1'b1 && w < 2000) begin
      @(negedge CLK);
      w++;
    end
    if (CMD_RDY !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_ready_timeout: CMD_RDY=%b expected 1", CMD_RDY);
    end
    for (int i = 0; i < n; i++) begin
      e.data = bytes[i];
      e.par  = (^bytes[i]) ^ pt;
      e.p    = peff;
      e.pe   = pe;
      exp_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    CMD_VLD = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int acc_cyc, output int lat, output int busy_cyc);
    lat = -1;
    busy_cyc = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      if (BUSY === 1'b1) busy_cyc++;
      if (FRAME_DONE === 1'b1) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_done_timeout: no FRAME_DONE within 6000 cycles");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if ({TX_OUT, CMD_RDY, BUSY, FRAME_DONE} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL reset_outputs: TX/RDY/BUSY/DONE got %b expected 1100",
               {TX_OUT, CMD_RDY, BUSY, FRAME_DONE});
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({TX_OUT, CMD_RDY, BUSY, FRAME_DONE} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: TX/RDY/BUSY/DONE got %b expected 1100",
               {TX_OUT, CMD_RDY, BUSY, FRAME_DONE});
    end
  endtask

  task automatic test_reg_wr();
    int acc, n, lat, bc, exp_lat;
    @(negedge CLK);
    drive_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 6'd8, acc, n);
    exp_lat = calc_latency(n, 1'b1, 8);
    wait_done(acc, lat, bc);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("[TB] FAIL reg_wr_latency: got %0d expected %0d", lat, exp_lat);
    end
    checks++;
    if ({CMD_RDY, BUSY} !== 2'b10 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL reg_wr_done_state: RDY/BUSY got %b expected 10, pending frames %0d expected 0",
               {CMD_RDY, BUSY}, exp_q.size());
    end
    @(negedge CLK);
    checks++;
    if (FRAME_DONE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reg_wr_done_pulse: FRAME_DONE got %b expected 0 one cycle later", FRAME_DONE);
    end
  endtask

  task automatic test_reg_rd();
    int acc, n, lat, bc, exp_lat;
    @(negedge CLK);
    drive_cmd(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 6'd16, acc, n);
    exp_lat = calc_latency(n, 1'b0, 16);
    wait_done(acc, lat, bc);
    checks++;
    if (lat != exp_lat || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL reg_rd_latency: got %0d expected %0d, pending frames %0d expected 0",
               lat, exp_lat, exp_q.size());
    end
  endtask

  task automatic test_alu_op();
    int acc, n, lat, bc, exp_lat;
    @(negedge CLK);
    drive_cmd(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1, 1'b1, 1'b1, 6'd8, acc, n);
    exp_lat = calc_latency(n, 1'b1, 8);
    wait_done(acc, lat, bc);
    checks++;
    if (bc != 353) begin
      errors++;
      $display("[TB] FAIL alu_op_busy_cycles: got %0d expected %0d", bc, 353);
    end
    checks++;
    if (lat != exp_lat || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL alu_op_latency: got %0d expected %0d, pending frames %0d expected 0",
               lat, exp_lat, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc, n, lat, bc, exp_lat;
    @(negedge CLK);
    drive_cmd(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7, 1'b0, 1'b0, 6'd0, acc, n);
    exp_lat = calc_latency(n, 1'b0, 8);
    wait_done(acc, lat, bc);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("[TB] FAIL nop_p0_latency: got %0d expected %0d", lat, exp_lat);
    end
    drive_cmd(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hA, 1'b1, 1'b0, 6'd1, acc, n);
    checks++;
    if (acc - (cyc - 0) != 0) begin
      errors++;
      $display("[TB] FAIL b2b_accept_cycle: got %0d expected %0d", acc, cyc);
    end
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_line_after_accept: TX_OUT got %b expected 1", TX_OUT);
    end
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_start_bit: TX_OUT got %b expected 0 one cycle after accept", TX_OUT);
    end
    exp_lat = calc_latency(n, 1'b1, 8);
    wait_done(acc, lat, bc);
    checks++;
    if (lat != exp_lat || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_latency: got %0d expected %0d, pending frames %0d expected 0",
               lat, exp_lat, exp_q.size());
    end
  endtask

  task automatic test_ignored_vld();
    int acc, n, lat, bc, exp_lat, bad;
    @(negedge CLK);
    drive_cmd(2'd0, 4'hF, 8'h81, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 6'd10, acc, n);
    exp_lat = calc_latency(n, 1'b1, 10);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (CMD_RDY !== 1'b0) bad++;
      CMD_VLD   = 1'b1;
      CMD_TYPE  = 2'($urandom);
      CMD_ADDR  = 4'($urandom);
      CMD_WDATA = 8'($urandom);
      CMD_OP_A  = 8'($urandom);
      CMD_OP_B  = 8'($urandom);
      CMD_FUN   = 4'($urandom);
      PAR_EN    = ~PAR_EN;
      PAR_TYP   = 1'($urandom);
      Prescale  = 6'($urandom_range(2, 63));
    end
    CMD_VLD = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL busy_not_ready: CMD_RDY high on %0d busy cycles expected 0", bad);
    end
    wait_done(acc - 0, lat, bc);
    checks++;
    if (lat != exp_lat || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL ignored_vld_latency: got %0d expected %0d, pending frames %0d expected 0",
               lat, exp_lat, exp_q.size());
    end
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (BUSY !== 1'b0 || TX_OUT !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL ignored_vld_not_queued: %0d active cycles after done expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc, n, lat, bc, exp_lat;
    @(negedge CLK);
    drive_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 6'd8, acc, n);
    repeat (110) @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if ({TX_OUT, CMD_RDY, BUSY, FRAME_DONE} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL mid_frame_reset: TX/RDY/BUSY/DONE got %b expected 1100",
               {TX_OUT, CMD_RDY, BUSY, FRAME_DONE});
    end
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    drive_cmd(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 6'd8, acc, n);
    exp_lat = calc_latency(n, 1'b1, 8);
    wait_done(acc, lat, bc);
    checks++;
    if (lat != exp_lat || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL after_reset_reg_rd: latency got %0d expected %0d, pending frames %0d expected 0",
               lat, exp_lat, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reg_wr();
    test_reg_rd();
    test_alu_op();
    test_back_to_back();
    test_ignored_vld();
    test_reset_mid_frame();
    repeat (5) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
